// File: rtl/multicycle_cpu_if.sv
// Single-port memory bus between the core (master) and an external memory (slave).
// A request is held until mem_ready is seen; read data is valid in that same cycle.
interface multicycle_cpu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Parametrised multicycle core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over an external
// request/ready memory; stages are skipped per instruction type, memory waits stall.
module multicycle_cpu #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_cpu_if.master      mem,
  output logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  instr_retired,
  output logic                  halted,
  output logic                  illegal_op
);
  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_LOADI = 5'd1;
  localparam logic [4:0] OP_LOAD  = 5'd2;
  localparam logic [4:0] OP_STORE = 5'd3;
  localparam logic [4:0] OP_ADD   = 5'd4;
  localparam logic [4:0] OP_SUB   = 5'd5;
  localparam logic [4:0] OP_AND   = 5'd6;
  localparam logic [4:0] OP_OR    = 5'd7;
  localparam logic [4:0] OP_BEQ   = 5'd8;
  localparam logic [4:0] OP_JMP   = 5'd9;
  localparam logic [4:0] OP_HALT  = 5'd10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALTED
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, npc_q, npc_d;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic                  ill_q, ill_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

  logic [4:0]            op;
  logic [IDX_W-1:0]      rd_idx, rs0_idx, rs1_idx, idx_a, idx_b;
  logic [DATA_WIDTH-1:0] opnd_a, opnd_b;
  logic [ADDR_WIDTH-1:0] br_tgt, jmp_tgt;
  logic                  wb_en, req_c, we_c, retired_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  assign op      = ir_q[31:27];
  assign rd_idx  = ir_q[22 +: IDX_W];
  assign rs0_idx = ir_q[17 +: IDX_W];
  assign rs1_idx = ir_q[12 +: IDX_W];

  // BEQ compares the rd and rs0 fields instead of rs0 and rs1
  assign idx_a  = (op == OP_BEQ) ? rd_idx  : rs0_idx;
  assign idx_b  = (op == OP_BEQ) ? rs0_idx : rs1_idx;
  assign opnd_a = (idx_a == '0) ? '0 : regs_q[idx_a];
  assign opnd_b = (idx_b == '0) ? '0 : regs_q[idx_b];

  assign br_tgt  = ADDR_WIDTH'(32'(pc_q) + {{15{ir_q[16]}}, ir_q[16:0]});
  assign jmp_tgt = ADDR_WIDTH'({10'b0, ir_q[21:0]});

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    ill_d     = ill_q;
    wb_en     = 1'b0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    retired_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata[31:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = opnd_a;
        b_d     = opnd_b;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        npc_d = pc_q + ADDR_WIDTH'(1);
        case (op)
          OP_LOADI: res_d = DATA_WIDTH'(ir_q[21:0]);
          OP_ADD:   res_d = a_q + b_q;
          OP_SUB:   res_d = a_q - b_q;
          OP_AND:   res_d = a_q & b_q;
          OP_OR:    res_d = a_q | b_q;
          OP_BEQ:   if (a_q == b_q) npc_d = br_tgt;
          OP_JMP:   npc_d = jmp_tgt;
          OP_NOP, OP_LOAD, OP_STORE, OP_HALT: ;
          default:  ill_d = 1'b1;
        endcase
        state_d = (op == OP_LOAD || op == OP_STORE) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        req_c   = 1'b1;
        we_c    = (op == OP_STORE);
        addr_c  = a_q[ADDR_WIDTH-1:0];
        wdata_c = b_q;
        if (mem.mem_ready) begin
          if (op == OP_LOAD) res_d = mem.mem_rdata;
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        retired_c = 1'b1;
        wb_en = (rd_idx != '0) &&
                (op == OP_LOADI || op == OP_LOAD || op == OP_ADD ||
                 op == OP_SUB || op == OP_AND || op == OP_OR);
        if (op == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          pc_d    = npc_q;
          state_d = S_FETCH;
        end
      end
      S_HALTED: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      npc_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[rd_idx] <= res_q;
    end
  end

  // Reset sits in FETCH, so the request is masked while rst is held low.
  assign mem.mem_req   = req_c & rst;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;

  assign pc_value      = pc_q;
  assign instr_retired = retired_c;
  assign halted        = (state_q == S_HALTED);
  assign illegal_op    = ill_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: table-driven ALU programs, hand-written corner sequences,
// and random programs checked against an instruction-level reference interpreter.
module tb_multicycle_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;

  multicycle_cpu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus ();
  logic [10:0] pc_value;
  logic        instr_retired, halted, illegal_op;

  multicycle_cpu #(.DATA_WIDTH(32), .REG_COUNT(32), .ADDR_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .mem(bus), .pc_value(pc_value),
    .instr_retired(instr_retired), .halted(halted), .illegal_op(illegal_op)
  );

  multicycle_cpu_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) bus2 ();
  logic [3:0] pc2;
  logic       ret2, halt2, ill2;

  multicycle_cpu #(.DATA_WIDTH(64), .REG_COUNT(8), .ADDR_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst2), .mem(bus2), .pc_value(pc2),
    .instr_retired(ret2), .halted(halt2), .illegal_op(ill2)
  );

  logic [31:0] tmem [2048];
  logic [31:0] mm   [2048];
  logic [63:0] mem2 [16];

  int  nvec = 0;
  int  nmis = 0;
  int  wait_cfg = 0;
  bit  hold = 1'b0;
  int  cnt = 0;
  int  retq [$];
  logic [10:0] cap_addr;
  logic        cap_we;
  logic [31:0] cap_wd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // memory responder: ready after wait_cfg stall cycles, bus must stay stable meanwhile
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        cnt = 0;
        bus.mem_ready = 1'b0;
      end else if (bus.mem_req && !hold) begin
        if (cnt == 0) begin
          cap_addr = bus.mem_addr; cap_we = bus.mem_we; cap_wd = bus.mem_wdata;
        end else begin
          chk("bus_stable", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, {cap_addr, cap_we, cap_wd});
        end
        if (cnt >= wait_cfg) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = tmem[bus.mem_addr];
          if (bus.mem_we) tmem[bus.mem_addr] = bus.mem_wdata;
          cnt = 0;
        end else begin
          bus.mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        bus.mem_ready = 1'b0;
        if (!bus.mem_req) cnt = 0;
      end
    end
  end

  initial begin
    bus2.mem_ready = 1'b1;
    bus2.mem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (rst2 && bus2.mem_req) begin
        bus2.mem_rdata = mem2[bus2.mem_addr];
        if (bus2.mem_we) mem2[bus2.mem_addr] = bus2.mem_wdata;
      end
    end
  end

  function automatic logic [31:0] i_r(logic [4:0] op, logic [4:0] rd, logic [4:0] s0, logic [4:0] s1);
    return {op, rd, s0, s1, 12'h000};
  endfunction
  function automatic logic [31:0] i_i(logic [4:0] op, logic [4:0] rd, logic [21:0] imm);
    return {op, rd, imm};
  endfunction
  function automatic logic [31:0] i_b(logic [4:0] x, logic [4:0] y, logic [16:0] off);
    return {5'd8, x, y, off};
  endfunction

  task automatic clear_mem(input bit rnd);
    for (int i = 0; i < 2048; i++) begin
      tmem[i] = rnd ? $urandom : 32'h0;
      mm[i]   = tmem[i];
    end
  endtask

  task automatic put(input int a, input logic [31:0] w);
    tmem[a] = w;
    mm[a]   = w;
  endtask

  // instruction-level interpreter: architectural effects plus stage-count timing
  task automatic model_run(input int w, output int pc_o, output int ret_o, output int cyc_o,
                           output bit ill_o, output bit ok_o);
    logic [31:0] r [32];
    logic [31:0] ir, va, vb, vd, res;
    int pc, npc, op, rd, s0, s1, off;
    bit wr;
    for (int i = 0; i < 32; i++) r[i] = 0;
    pc = 0; ret_o = 0; cyc_o = 0; ill_o = 0; ok_o = 0; pc_o = 0;
    for (int step = 0; step < 300; step++) begin
      ir = mm[pc];
      op = int'(ir[31:27]); rd = int'(ir[26:22]); s0 = int'(ir[21:17]); s1 = int'(ir[16:12]);
      va = (s0 == 0) ? 32'h0 : r[s0];
      vb = (s1 == 0) ? 32'h0 : r[s1];
      vd = (rd == 0) ? 32'h0 : r[rd];
      cyc_o += 4 + w;
      ret_o++;
      npc = (pc + 1) % 2048;
      wr = 0; res = 0;
      case (op)
        0: ;
        1: begin wr = 1; res = {10'b0, ir[21:0]}; end
        2: begin cyc_o += 1 + w; wr = 1; res = mm[va[10:0]]; end
        3: begin cyc_o += 1 + w; mm[va[10:0]] = vb; end
        4: begin wr = 1; res = va + vb; end
        5: begin wr = 1; res = va - vb; end
        6: begin wr = 1; res = va & vb; end
        7: begin wr = 1; res = va | vb; end
        8: begin
          off = ir[16] ? int'(ir[16:0]) - 131072 : int'(ir[16:0]);
          if (vd == va) npc = ((pc + off) % 2048 + 2048) % 2048;
        end
        9: npc = int'(ir[10:0]);
        10: begin pc_o = pc; ok_o = 1; return; end
        default: ill_o = 1;
      endcase
      if (wr && rd != 0) r[rd] = res;
      pc = npc;
    end
  endtask

  task automatic run_dut(input int w, input int budget, output int pc_o, output int ret_o,
                         output int last_o, output bit ill_o, output bit to_o);
    int cyc;
    rst = 1'b0; wait_cfg = w; hold = 1'b0; cnt = 0;
    ret_o = 0; last_o = 0; retq.delete();
    @(negedge clk);
    rst = 1'b1;
    #2;
    cyc = 1;
    while (!halted && cyc <= budget) begin
      if (instr_retired) begin
        ret_o++; last_o = cyc; retq.push_back(cyc);
      end
      @(negedge clk); #2;
      cyc++;
    end
    to_o  = !halted;
    pc_o  = int'(pc_value);
    ill_o = illegal_op;
    if (to_o) begin
      nvec++; nmis++;
      $display("FAIL run_timeout: got no halt after %0d cycles, expected halt", budget);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [21:0] a;
    logic [21:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  initial begin
    alu_vec_t vt [6];
    int exp_r [5];
    int pc_o, ret_o, last_o, mpc, mret, mcyc, w, diffs, c2, n2;
    bit ill_o, to_o, mill, mok;

    vt[0] = '{5'd4, 22'd5,       22'd7,       32'd12};
    vt[1] = '{5'd5, 22'd5,       22'd7,       32'hFFFF_FFFE};
    vt[2] = '{5'd6, 22'h3F0F0F,  22'h0FF0F0,  32'h000F_0000};
    vt[3] = '{5'd7, 22'h3F0F0F,  22'h0FF0F0,  32'h003F_FFFF};
    vt[4] = '{5'd4, 22'h3FFFFF,  22'h3FFFFF,  32'h007F_FFFE};
    vt[5] = '{5'd5, 22'd0,       22'd1,       32'hFFFF_FFFF};
    exp_r = '{4, 8, 12, 17, 21};
    for (int i = 0; i < 16; i++) mem2[i] = '0;

    // reset mid-FETCH with the memory stalled
    clear_mem(0);
    put(0, 32'hF800_0000); put(1, 32'h0); put(2, i_i(5'd10, 0, 0));
    rst = 1'b0; wait_cfg = 0; hold = 1'b0;
    @(negedge clk); rst = 1'b1; #2;
    repeat (7) begin @(negedge clk); #2; end
    hold = 1'b1;
    @(negedge clk); #2;
    chk("stall_req", bus.mem_req, 1);
    chk("stall_addr", bus.mem_addr, 2);
    chk("stall_illegal", illegal_op, 1);
    rst = 1'b0; #1;
    chk("rst_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    chk("rst_status", {instr_retired, halted, illegal_op, pc_value}, 0);
    @(negedge clk); rst = 1'b1; hold = 1'b0; #2;
    chk("rst_first_fetch", {bus.mem_req, bus.mem_addr}, {1'b1, 11'd0});

    // reference program, ready effectively tied high
    clear_mem(0);
    put(0, i_i(5'd1, 1, 22'd5)); put(1, i_i(5'd1, 2, 22'd7)); put(2, i_r(5'd4, 3, 1, 2));
    put(3, i_r(5'd3, 0, 1, 3));  put(4, i_i(5'd10, 0, 0));
    run_dut(0, 100, pc_o, ret_o, last_o, ill_o, to_o);
    chk("prog_mem5", tmem[5], 12);
    chk("prog_halted", halted, 1);
    chk("prog_pc", pc_o, 4);
    chk("prog_nretire", retq.size(), 5);
    for (int i = 0; i < 5 && i < retq.size(); i++) chk($sformatf("prog_retire%0d", i), retq[i], exp_r[i]);

    // three wait cycles on every request, including LOAD with rd == rs0
    clear_mem(0);
    put(40, 32'hABCD);
    put(0, i_i(5'd1, 1, 22'd40)); put(1, i_r(5'd2, 4, 1, 0)); put(2, i_r(5'd2, 1, 1, 0));
    put(3, i_i(5'd1, 2, 22'd41)); put(4, i_r(5'd3, 0, 2, 4));  put(5, i_i(5'd1, 3, 22'd42));
    put(6, i_r(5'd3, 0, 3, 1));   put(7, i_i(5'd10, 0, 0));
    run_dut(3, 300, pc_o, ret_o, last_o, ill_o, to_o);
    chk("wait_load", tmem[41], 32'hABCD);
    chk("wait_load_rd_eq_rs0", tmem[42], 32'hABCD);
    chk("wait_cycles", last_o, 72);

    // branches: taken backwards, not taken, wrap below zero
    clear_mem(0);
    put(0, i_i(5'd9, 0, 22'd10)); put(10, i_b(0, 0, 17'h1FFFF)); put(9, i_i(5'd10, 0, 0));
    run_dut(0, 100, pc_o, ret_o, last_o, ill_o, to_o);
    chk("beq_taken_pc", pc_o, 9);
    chk("beq_taken_nret", ret_o, 3);
    clear_mem(0);
    put(0, i_i(5'd1, 1, 22'd1)); put(1, i_i(5'd9, 0, 22'd10)); put(10, i_b(1, 0, 17'h1FFFF));
    put(9, i_i(5'd10, 0, 0));    put(11, i_i(5'd10, 0, 0));
    run_dut(0, 100, pc_o, ret_o, last_o, ill_o, to_o);
    chk("beq_not_taken_pc", pc_o, 11);
    clear_mem(0);
    put(0, i_b(0, 0, 17'h1FFFF)); put(2047, i_i(5'd10, 0, 0));
    run_dut(0, 100, pc_o, ret_o, last_o, ill_o, to_o);
    chk("beq_wrap_pc", pc_o, 2047);

    // r0 stays zero; undefined opcode is a sticky NOP
    clear_mem(0);
    put(50, 32'hDEAD);
    put(0, i_i(5'd1, 0, 22'd9)); put(1, i_r(5'd4, 5, 0, 0)); put(2, i_i(5'd1, 6, 22'd50));
    put(3, i_r(5'd3, 0, 6, 5));  put(4, 32'hFFFF_FFFF);      put(5, i_i(5'd10, 0, 0));
    run_dut(1, 200, pc_o, ret_o, last_o, ill_o, to_o);
    chk("r0_zero", tmem[50], 0);
    chk("illegal_sticky", ill_o, 1);
    chk("illegal_pc", pc_o, 5);

    // table-driven ALU checks
    for (int i = 0; i < 6; i++) begin
      w = i % 3;
      clear_mem(0);
      put(0, i_i(5'd1, 1, vt[i].a)); put(1, i_i(5'd1, 2, vt[i].b)); put(2, i_r(vt[i].op, 3, 1, 2));
      put(3, i_i(5'd1, 4, 22'd100)); put(4, i_r(5'd3, 0, 4, 3));   put(5, i_i(5'd10, 0, 0));
      run_dut(w, 200, pc_o, ret_o, last_o, ill_o, to_o);
      chk($sformatf("alu_vec%0d", i), tmem[100], vt[i].exp);
      chk($sformatf("alu_cyc%0d", i), last_o, 25 + 7 * w);
    end

    // random programs against the interpreter
    for (int p = 0; p < 20; p++) begin
      mok = 0;
      while (!mok) begin
        clear_mem(1);
        for (int i = 0; i < 12; i++) begin
          logic [4:0] rd, s0, s1;
          int k;
          k = $urandom_range(0, 9);
          rd = 5'($urandom_range(0, 7)); s0 = 5'($urandom_range(0, 7)); s1 = 5'($urandom_range(0, 7));
          case (k)
            0: put(i, i_i(5'd1, rd, 22'($urandom)));
            1, 2, 3, 4: put(i, i_r(5'(k + 3), rd, s0, s1));
            5: put(i, i_r(5'd3, 0, s0, s1));
            6: put(i, i_r(5'd2, rd, s0, 0));
            7: put(i, 32'h0);
            8: put(i, i_b(rd, s0, 17'($urandom_range(1, 12 - i))));
            default: put(i, i_i(5'($urandom_range(11, 31)), rd, 22'($urandom)));
          endcase
        end
        put(12, i_i(5'd10, 0, 0));
        w = $urandom_range(0, 2);
        model_run(w, mpc, mret, mcyc, mill, mok);
      end
      run_dut(w, mcyc + 100, pc_o, ret_o, last_o, ill_o, to_o);
      diffs = 0;
      for (int a = 0; a < 2048; a++) if (tmem[a] !== mm[a]) diffs++;
      chk($sformatf("rnd%0d_mem_diffs", p), diffs, 0);
      chk($sformatf("rnd%0d_pc", p), pc_o, mpc);
      chk($sformatf("rnd%0d_nret", p), ret_o, mret);
      chk($sformatf("rnd%0d_cycles", p), last_o, mcyc);
      chk($sformatf("rnd%0d_illegal", p), ill_o, mill);
    end

    // narrow-address, wide-data instance: 64-bit wrap, index aliasing, PC wrap 15->0
    mem2[0] = {32'h0, i_b(5, 0, 17'd2)};
    mem2[1] = {32'h0, i_i(5'd10, 0, 0)};
    mem2[2] = {32'h0, i_i(5'd1, 9, 22'd13)};
    mem2[3] = {32'h0, i_i(5'd1, 2, 22'd1)};
    mem2[4] = {32'h0, i_r(5'd5, 3, 0, 2)};
    mem2[5] = {32'h0, i_r(5'd4, 4, 3, 3)};
    mem2[6] = {32'h0, i_r(5'd3, 0, 1, 4)};
    mem2[7] = {32'h0, i_i(5'd1, 5, 22'd1)};
    mem2[8] = {32'h0, i_i(5'd9, 0, 22'd15)};
    @(negedge clk); rst2 = 1'b1; #2;
    c2 = 1; n2 = 0; last_o = 0;
    while (!halt2 && c2 <= 200) begin
      if (ret2) begin n2++; last_o = c2; end
      @(negedge clk); #2;
      c2++;
    end
    chk("w64_halted", halt2, 1);
    chk("w64_wrap_add", mem2[13], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("w64_pc", pc2, 1);
    chk("w64_nretire", n2, 11);
    chk("w64_cycles", last_o, 45);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
